// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer.
package cnn_pkg;

  localparam int KSEL_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [KSEL_WIDTH_DEF-1:0] K_IDENTITY        = 5'd0;
  localparam logic [KSEL_WIDTH_DEF-1:0] K_GAUSSIAN_BLUR_1 = 5'd1;
  localparam logic [KSEL_WIDTH_DEF-1:0] K_GAUSSIAN_BLUR_2 = 5'd2;
  localparam logic [KSEL_WIDTH_DEF-1:0] K_SHARPEN         = 5'd3;
  localparam logic [KSEL_WIDTH_DEF-1:0] K_EDGE_DETECT     = 5'd4;

endpackage

// File: rtl/cnn_frame_counter.sv
// Raster row/column counter: column returns to 0 after wrap_col, row advances on that wrap.
module cnn_frame_counter #(
  parameter int CW = 11,
  parameter int RW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] wrap_col,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      if (col_q == wrap_col) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: validates config, clears the CNN, streams pixels in and
// tags convolution results with end-of-line / end-of-frame markers.
module cnn_frame_ctrl
  import cnn_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int KERNEL_SIZE   = 3,
  parameter int ROW_WIDTH     = 12,
  parameter int KSEL_WIDTH    = KSEL_WIDTH_DEF,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int CW           = $clog2(BUFFER_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROW_WIDTH-1:0]   cfg_rows,
  input  logic [CW-1:0]          cfg_cols,
  input  logic [KSEL_WIDTH-1:0]  cfg_kernel,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   cnn_rst_n,
  output logic [PIXEL_WIDTH-1:0] cnn_in_point,
  output logic                   cnn_valid_in,
  output logic [CW-1:0]          cnn_frame_column_size,
  output logic [KSEL_WIDTH-1:0]  cnn_kernel_type,
  input  logic [PIXEL_WIDTH-1:0] cnn_conv_res,
  input  logic                   cnn_valid_out,
  output logic [PIXEL_WIDTH-1:0] m_pixel,
  output logic                   m_valid,
  output logic                   m_eol,
  output logic                   m_eof
);

  localparam int EW = ROW_WIDTH + CW;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ROW_WIDTH-1:0] K_R    = ROW_WIDTH'(KERNEL_SIZE);
  localparam logic [CW-1:0]        K_C    = CW'(KERNEL_SIZE);
  localparam logic [ROW_WIDTH-1:0] KM1_R  = ROW_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0]        KM1_C  = CW'(KERNEL_SIZE - 1);
  localparam logic [CW:0]          BUF_LIM = (CW+1)'(BUFFER_LENGTH);

  state_e                 state_q, state_d;
  logic [ROW_WIDTH-1:0]   rows_q, rows_d;
  logic [CW-1:0]          cols_q, cols_d;
  logic [KSEL_WIDTH-1:0]  kern_q, kern_d;
  logic [EW-1:0]          expected_q, expected_d;
  logic [EW-1:0]          out_cnt_q, out_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                   s_ready_q, s_ready_d, cnn_rst_q, cnn_rst_d;
  logic                   vin_q, vin_d;
  logic [PIXEL_WIDTH-1:0] pt_q, pt_d, m_pix_q, m_pix_d;
  logic                   m_val_q, m_val_d, m_eol_q, m_eol_d, m_eof_q, m_eof_d;

  logic [CW-1:0]          in_col, out_col;
  logic [ROW_WIDTH-1:0]   in_row, out_row;
  logic [ROW_WIDTH-1:0]   win_rows;
  logic [CW-1:0]          win_cols;
  logic                   hs, res_acc, cfg_bad, in_last, cnt_clr;

  assign cnt_clr  = (state_q == CLR);
  assign hs       = s_valid && s_ready_q;
  assign res_acc  = (state_q == STREAM || state_q == DRAIN) && cnn_valid_out &&
                    (out_cnt_q != expected_q);
  assign in_last  = (in_col == cols_q - CW'(1)) && (in_row == rows_q - ROW_WIDTH'(1));
  assign cfg_bad  = (cfg_rows < K_R) || (cfg_cols < K_C) || ({1'b0, cfg_cols} > BUF_LIM);
  assign win_rows = cfg_rows - KM1_R;
  assign win_cols = cfg_cols - KM1_C;

  cnn_frame_counter #(.CW(CW), .RW(ROW_WIDTH)) u_in_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (hs),
    .wrap_col (cols_q - CW'(1)),
    .col      (in_col),
    .row      (in_row)
  );

  cnn_frame_counter #(.CW(CW), .RW(ROW_WIDTH)) u_out_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (res_acc),
    .wrap_col (cols_q - K_C),
    .col      (out_col),
    .row      (out_row)
  );

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    kern_d     = kern_q;
    expected_d = expected_q;
    out_cnt_d  = out_cnt_q;
    to_cnt_d   = '0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    vin_d      = 1'b0;
    pt_d       = pt_q;
    m_pix_d    = m_pix_q;
    m_val_d    = 1'b0;
    m_eol_d    = 1'b0;
    m_eof_d    = 1'b0;

    if (cnt_clr) out_cnt_d = '0;

    if (res_acc) begin
      out_cnt_d = out_cnt_q + EW'(1);
      m_val_d   = 1'b1;
      m_pix_d   = cnn_conv_res;
      m_eol_d   = (out_col == cols_q - K_C);
      m_eof_d   = (out_cnt_q == expected_q - EW'(1)) && (out_row == rows_q - K_R);
    end

    case (state_q)
      IDLE: if (start) begin
        if (cfg_bad) begin
          error_d = 1'b1;
        end else begin
          rows_d     = cfg_rows;
          cols_d     = cfg_cols;
          kern_d     = cfg_kernel;
          expected_d = {{CW{1'b0}}, win_rows} * {{ROW_WIDTH{1'b0}}, win_cols};
          state_d    = CLR;
        end
      end
      CLR: state_d = STREAM;
      STREAM: if (hs) begin
        vin_d = 1'b1;
        pt_d  = s_pixel;
        if (in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt_d == expected_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          // idle-cycle watchdog; any CNN result restarts the count
          to_cnt_d = cnn_valid_out ? '0 : to_cnt_q + TW'(1);
          if (to_cnt_d == TW'(DRAIN_TIMEOUT)) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d == STREAM);
    cnn_rst_d = (state_d != CLR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      kern_q     <= '0;
      expected_q <= '0;
      out_cnt_q  <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      s_ready_q  <= 1'b0;
      cnn_rst_q  <= 1'b1;
      vin_q      <= 1'b0;
      pt_q       <= '0;
      m_pix_q    <= '0;
      m_val_q    <= 1'b0;
      m_eol_q    <= 1'b0;
      m_eof_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      kern_q     <= kern_d;
      expected_q <= expected_d;
      out_cnt_q  <= out_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      s_ready_q  <= s_ready_d;
      cnn_rst_q  <= cnn_rst_d;
      vin_q      <= vin_d;
      pt_q       <= pt_d;
      m_pix_q    <= m_pix_d;
      m_val_q    <= m_val_d;
      m_eol_q    <= m_eol_d;
      m_eof_q    <= m_eof_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign s_ready               = s_ready_q;
  assign cnn_rst_n             = rst_n && cnn_rst_q;
  assign cnn_in_point          = pt_q;
  assign cnn_valid_in          = vin_q;
  assign cnn_frame_column_size = cols_q;
  assign cnn_kernel_type       = kern_q;
  assign m_pixel               = m_pix_q;
  assign m_valid               = m_val_q;
  assign m_eol                 = m_eol_q;
  assign m_eof                 = m_eof_q;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Random-frame bench: a 3x3-sum CNN stand-in feeds results back, a scoreboard
// predicts tagged results from the source frame, monitors compare at negedge.
module tb_cnn_frame_ctrl;
  import cnn_pkg::K_IDENTITY;
  import cnn_pkg::K_GAUSSIAN_BLUR_1;
  import cnn_pkg::K_SHARPEN;

  logic        clk, rst_n, start;
  logic [11:0] cfg_rows;
  logic [10:0] cfg_cols;
  logic [4:0]  cfg_kernel;
  logic        busy, done, error;
  logic [7:0]  s_pixel;
  logic        s_valid, s_ready;
  logic        cnn_rst_n;
  logic [7:0]  cnn_in_point;
  logic        cnn_valid_in;
  logic [10:0] cnn_frame_column_size;
  logic [4:0]  cnn_kernel_type;
  logic [7:0]  cnn_conv_res;
  logic        cnn_valid_out;
  logic [7:0]  m_pixel;
  logic        m_valid, m_eol, m_eof;

  cnn_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_kernel(cfg_kernel),
    .busy(busy), .done(done), .error(error),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .cnn_rst_n(cnn_rst_n), .cnn_in_point(cnn_in_point), .cnn_valid_in(cnn_valid_in),
    .cnn_frame_column_size(cnn_frame_column_size), .cnn_kernel_type(cnn_kernel_type),
    .cnn_conv_res(cnn_conv_res), .cnn_valid_out(cnn_valid_out),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_eol(m_eol), .m_eof(m_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] pix; logic eol; logic eof; } res_t;

  res_t       exp_q[$];
  res_t       mon_e;
  int         nchk = 0, npass = 0, cyc = 0;
  int         vin_cnt = 0, mval_cnt = 0, rdy_cnt = 0, last_mval_cyc = 0;
  int         mdl_cols = 3, mdl_supp = -1, mdl_n = 0, mdl_wins = 0;
  bit         mon_en = 1'b0;
  logic       hs_prev = 1'b0;
  logic [7:0] pix_prev = 8'd0;
  logic [7:0] mem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // CNN stand-in: one result per completed 3x3 window, equal to the window sum mod 256
  function automatic logic [7:0] mdl_sum(input int n, input int cols, input logic [7:0] p);
    logic [7:0] s;
    int r, c;
    s = p;
    r = n / cols;
    c = n % cols;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (dr != 0 || dc != 0) s = s + mem[(r - dr) * cols + (c - dc)];
    return s;
  endfunction

  always @(posedge clk) begin
    if (!cnn_rst_n) begin
      mdl_n         <= 0;
      mdl_wins      <= 0;
      cnn_valid_out <= 1'b0;
    end else begin
      cnn_valid_out <= 1'b0;
      if (cnn_valid_in) begin
        mem[mdl_n] <= cnn_in_point;
        mdl_n      <= mdl_n + 1;
        if (mdl_n / mdl_cols >= 2 && mdl_n % mdl_cols >= 2 &&
            (mdl_supp < 0 || mdl_wins < mdl_supp)) begin
          cnn_valid_out <= 1'b1;
          cnn_conv_res  <= mdl_sum(mdl_n, mdl_cols, cnn_in_point);
          mdl_wins      <= mdl_wins + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    hs_prev  <= rst_n && s_valid && s_ready;
    pix_prev <= s_pixel;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cnn_valid_in_mirror", cnn_valid_in, hs_prev);
      if (hs_prev) chk("cnn_in_point", cnn_in_point, pix_prev);
      if (cnn_valid_in) vin_cnt++;
      if (s_ready) rdy_cnt++;
      if (m_valid) begin
        mval_cnt++;
        last_mval_cyc = cyc;
        if (exp_q.size() == 0) chk("m_valid_unexpected", m_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("m_pixel", m_pixel, mon_e.pix);
          chk("m_eol", m_eol, mon_e.eol);
          chk("m_eof", m_eof, mon_e.eof);
        end
      end
    end
  end

  // vmode: 0 always valid, 1 pattern 1,0,0,1, 2 random; poke_at/rst_at are stream-cycle indices
  task automatic run_frame(input int rows, input int cols, input logic [4:0] kern,
                           input int vmode, input int supp, input int poke_at, input int rst_at);
    logic [7:0] fr[$];
    logic [7:0] s;
    res_t       e;
    int         n, nwin, nexp, k, idx, sc;
    bit         rdy, got, to_exp;
    logic [3:0] pat;
    pat = 4'b1001;
    n = rows * cols;
    fr = {};
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
    nwin   = (rows - 2) * (cols - 2);
    nexp   = (supp >= 0 && supp < nwin) ? supp : nwin;
    to_exp = (nexp < nwin);
    k = 0;
    for (int r = 2; r < rows; r++)
      for (int c = 2; c < cols; c++) begin
        k++;
        if (k <= nexp) begin
          s = 8'd0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) s = s + fr[(r - dr) * cols + (c - dc)];
          e.pix = s;
          e.eol = (c == cols - 1);
          e.eof = (k == nwin);
          exp_q.push_back(e);
        end
      end

    @(negedge clk);
    cfg_rows = 12'(rows); cfg_cols = 11'(cols); cfg_kernel = kern;
    mdl_cols = cols; mdl_supp = supp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_clr", busy, 1);
    chk("cnn_rst_n_in_clr", cnn_rst_n, 0);
    chk("s_ready_in_clr", s_ready, 0);
    vin_cnt = 0; mval_cnt = 0; rdy_cnt = 0;

    idx = 0; sc = 0;
    while (idx < n && sc < 5000) begin
      @(negedge clk);
      if (sc == rst_at) begin
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_cnn_valid_in", cnn_valid_in, 0);
        chk("abort_cnn_rst_n", cnn_rst_n, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_kernel", cnn_kernel_type, 0);
        chk("abort_colsize", cnn_frame_column_size, 0);
        chk("abort_in_point", cnn_in_point, 0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (8) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        return;
      end
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = pat[sc % 4];
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_pixel = fr[idx];
      if (sc == poke_at) begin
        start = 1'b1; cfg_kernel = K_SHARPEN; cfg_cols = 11'd7; cfg_rows = 12'd9;
      end else start = 1'b0;
      rdy = s_ready;
      if (s_valid && rdy) idx++;
      sc++;
    end
    chk("stream_all_accepted", idx, n);

    got = 1'b0; sc = 0;
    while (!got && sc < 300) begin
      @(negedge clk);
      s_valid = 1'b0;
      start = 1'b0;
      sc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("error_with_done", error, to_exp);
      chk("eof_with_done", m_valid && m_eof, !to_exp);
      chk("busy_at_done", busy, !to_exp);
      if (to_exp)
        chk("timeout_delay", (cyc - last_mval_cyc >= 64) && (cyc - last_mval_cyc <= 64 + n), 1);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
    chk("result_count", mval_cnt, nexp);
    chk("cnn_valid_in_count", vin_cnt, n);
    chk("kernel_latched", cnn_kernel_type, kern);
    chk("colsize_latched", cnn_frame_column_size, cols);
    chk("scoreboard_drained", exp_q.size(), 0);
    if (vmode == 0) chk("s_ready_cycles", rdy_cnt, n);
    exp_q.delete();
  endtask

  task automatic bad_cfg(input int rows, input int cols);
    @(negedge clk);
    cfg_rows = 12'(rows); cfg_cols = 11'(cols);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_cfg_error", error, 1);
    chk("bad_cfg_busy", busy, 0);
    chk("bad_cfg_cnn_rst_n", cnn_rst_n, 1);
    chk("bad_cfg_s_ready", s_ready, 0);
    @(negedge clk);
    chk("bad_cfg_error_pulse", error, 0);
    chk("bad_cfg_busy_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_pixel = 8'd0;
    cfg_rows = 12'd0; cfg_cols = 11'd0; cfg_kernel = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cnn_valid_in", cnn_valid_in, 0);
    chk("rst_m_flags", {m_valid, m_eol, m_eof}, 0);
    chk("rst_cnn_rst_n", cnn_rst_n, 0);
    chk("rst_data", {m_pixel, cnn_in_point}, 0);
    chk("rst_latched_cfg", {cnn_frame_column_size, cnn_kernel_type}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cnn_rst_n", cnn_rst_n, 1);
    mon_en = 1'b1;

    run_frame(5, 4, K_GAUSSIAN_BLUR_1, 0, -1, -1, -1);
    bad_cfg(5, 2);
    bad_cfg(70, 2001);
    bad_cfg(2, 5);
    run_frame(5, 4, K_GAUSSIAN_BLUR_1, 1, -1, -1, -1);
    run_frame(5, 4, K_IDENTITY, 0, -1, 5, -1);
    run_frame(5, 4, K_SHARPEN, 2, -1, -1, -1);
    run_frame(5, 4, K_GAUSSIAN_BLUR_1, 0, 4, -1, -1);
    run_frame(5, 4, K_GAUSSIAN_BLUR_1, 0, -1, -1, 6);
    run_frame(3, 3, K_GAUSSIAN_BLUR_1, 0, -1, -1, -1);
    repeat (4)
      run_frame($urandom_range(3, 8), $urandom_range(3, 10), 5'($urandom_range(0, 31)),
                2, -1, -1, -1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/cnn_frame_ctrl.md
Name: cnn_frame_ctrl

Overview:
Frame-level sequencer for the CNN convolution pipeline (line buffer + 3×3 MAC). It accepts a start command and frame configuration, then clears the pipeline's line buffers. It streams source pixels into the pipeline with a ready/valid handshake and counts convolution results, tagging them with end-of-line and end-of-frame markers. It sits between the pixel source/DMA and the CNN instance, and owns its reset, kernel selection and column-size inputs.

Parameters:
PIXEL_WIDTH, 8, pixel and result width
BUFFER_LENGTH, 2000, max frame columns; sets column counter width CW=$clog2(BUFFER_LENGTH)
KERNEL_SIZE, 3, convolution window edge K
ROW_WIDTH, 12, frame row counter width
KSEL_WIDTH, 5, kernel_type select width
DRAIN_TIMEOUT, 64, idle cycles tolerated in DRAIN before error

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin frame (sampled in IDLE only)
cfg_rows  in  ROW_WIDTH  frame rows
cfg_cols  in  CW  frame columns
cfg_kernel  in  KSEL_WIDTH  kernel select
busy  out  1  high from CLR through DONE
done  out  1  one-cycle pulse at frame end
error  out  1  one-cycle pulse: bad config or drain timeout
s_pixel  in  PIXEL_WIDTH  source pixel
s_valid  in  1  source valid
s_ready  out  1  controller ready
cnn_rst_n  out  1  CNN reset, active-low
cnn_in_point  out  PIXEL_WIDTH  pixel to CNN
cnn_valid_in  out  1  pixel valid to CNN
cnn_frame_column_size  out  CW  latched cfg_cols
cnn_kernel_type  out  KSEL_WIDTH  latched cfg_kernel
cnn_conv_res  in  PIXEL_WIDTH  CNN result
cnn_valid_out  in  1  CNN result valid, one per complete window
m_pixel  out  PIXEL_WIDTH  result to sink
m_valid  out  1  result valid (no backpressure; sink must accept)
m_eol  out  1  last result of an output row, qualified by m_valid
m_eof  out  1  last result of frame, qualified by m_valid

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. All counters 0. busy, done, error, s_ready, cnn_valid_in, m_valid, m_eol and m_eof are 0. cnn_in_point, m_pixel, cnn_frame_column_size and cnn_kernel_type are 0. cnn_rst_n is 0 while rst_n is low. A reset mid-frame aborts the frame with no done pulse.
- States: IDLE, CLR, STREAM, DRAIN, DONE.
- IDLE + start: validate the config. If cfg_rows<K, cfg_cols<K, or cfg_cols>BUFFER_LENGTH: error pulses next cycle and the block stays IDLE. Otherwise latch rows, cols and kernel, compute expected = (rows-K+1)*(cols-K+1) with width ROW_WIDTH+CW, and go to CLR. start is ignored outside IDLE.
- CLR: exactly 1 cycle. cnn_rst_n=0, s_ready=0. Next state is STREAM.
- STREAM: s_ready=1. On s_valid&&s_ready, cnn_in_point/cnn_valid_in are registered with 1-cycle latency; otherwise cnn_valid_in=0. in_col wraps at cols-1 and in_row increments on wrap. On the accepting handshake of pixel rows*cols, s_ready drops in the same cycle as the registered transfer and the next state is DRAIN.
- Result path is active in STREAM and DRAIN. Each cnn_valid_out drives m_pixel/m_valid on the next cycle and increments out_cnt. out_col wraps at cols-K. m_eol is asserted when out_col==cols-K. m_eof is asserted when out_cnt==expected-1 before the increment. cnn_valid_out in IDLE, CLR, DONE, or after expected results is ignored (m_valid stays 0).
- DRAIN: when out_cnt reaches expected, go to DONE. The timeout counter resets on each cnn_valid_out. If it reaches DRAIN_TIMEOUT: error and done pulse together, then IDLE.
- DONE: 1 cycle. done=1, then IDLE. The last m_valid/m_eof coincides with the done pulse.
- If expected is already reached when the last pixel is accepted, the block passes through DRAIN for one cycle.
- cnn_kernel_type and cnn_frame_column_size change only on a valid start; cfg_* changes mid-frame have no effect.

Decomposition:
- Shared package cnn_pkg: state enum (IDLE, CLR, STREAM, DRAIN, DONE), K_* kernel select constants, and the KSEL_WIDTH default.
- One sub-module, cnn_frame_counter: a row/column counter with configurable wrap, instantiated for the input side (wrap cols-1) and the output side (wrap cols-K).

Test Plan:
- Frame rows=5, cols=4, kernel K_GAUSSIAN_BLUR_1, s_valid always high, CNN model emitting one valid_out per window -> s_ready high for 20 cycles after CLR; 6 m_valid results; m_eol on results 2, 4, 6; m_eof on result 6; done pulse in the same cycle as result 6; busy falls next cycle.
- start with cols=2 (and separately rows=70, cols=2001) -> error one-cycle pulse, busy stays 0, cnn_rst_n stays 1.
- Same 5×4 frame with s_valid toggling 1,0,0,1 -> cnn_valid_in mirrors the handshakes delayed by 1 cycle; exactly 20 cnn_valid_in pulses; no pixel dropped or duplicated.
- cfg_kernel changed from 0 to 3 and start pulsed during STREAM -> cnn_kernel_type and the state sequence are unaffected; the next frame picks up 3.
- CNN model suppresses valid_out after 4 results -> error and done pulse together 64 cycles after the last result; state returns to IDLE; no m_eof.
- rst_n low for 1 cycle mid-STREAM -> all outputs 0 the following cycle, no done pulse; a fresh start completes a 3×3 frame with 1 result carrying m_eol=m_eof=1.
